output_layer_acc: RTL and testbench

Fully connected output layer of the MNIST classifier. Streams one hidden-layer activation per beat together with that activation's 10 weights, and keeps one saturating signed accumulator per output class. When a frame is complete it presents the 10 class scores packed on `layer_out` with a one-cycle `valid` pulse. Sits directly upstream of the argmax comparator, which samples `layer_out` on the cycle `valid` is high.

---
 rtl/fc_pkg.sv | 27 ++
 rtl/mac_sat_lane.sv | 68 ++++++
 rtl/output_layer_acc.sv | 108 ++++++++++
 tb/tb_output_layer_acc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared constants and types for the fully connected output layer.
//   N_OUT             number of output classes (matches the argmax comparator)
//   DATA_WIDTH        default accumulator / score width
//   IN_WIDTH, W_WIDTH default activation and weight widths
//   ACC_MAX, ACC_MIN  clamp limits at the default DATA_WIDTH
//   fc_state_e        frame FSM states
package fc_pkg;

  localparam int N_OUT      = 10;
  localparam int DATA_WIDTH = 29;
  localparam int IN_WIDTH   = 8;
  localparam int W_WIDTH    = 8;
  localparam int N_IN       = 32;

  localparam logic signed [DATA_WIDTH-1:0] ACC_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] ACC_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } fc_state_e;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mac_sat_lane.sv
// mac_sat_lane: one output class. Registers act*w for each accepted beat,
// then folds it into a saturating signed accumulator. On a frame's first
// beat the accumulator restarts from the bias instead of its old value.
//   clk, rst      clock, synchronous active-high reset
//   beat_i        a beat transfers this edge
//   first_i       that beat opens a frame (capture bias)
//   act_i         unsigned activation
//   w_i, bias_i   signed weight and bias for this class
//   acc_en_i      product register holds a live beat
//   acc_first_i   that live beat was a frame's first
//   acc_o         current accumulator value
module mac_sat_lane
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = fc_pkg::DATA_WIDTH,
  parameter int IN_WIDTH   = fc_pkg::IN_WIDTH,
  parameter int W_WIDTH    = fc_pkg::W_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         beat_i,
  input  logic                         first_i,
  input  logic [IN_WIDTH-1:0]          act_i,
  input  logic signed [W_WIDTH-1:0]    w_i,
  input  logic signed [W_WIDTH-1:0]    bias_i,
  input  logic                         acc_en_i,
  input  logic                         acc_first_i,
  output logic signed [DATA_WIDTH-1:0] acc_o
);

  localparam int PW = IN_WIDTH + W_WIDTH + 1;
  // Sum is one bit wider than the wider of acc and product, so narrow
  // accumulators (smaller than a single product) still detect overflow.
  localparam int SW = max_i(DATA_WIDTH, PW) + 1;

  logic signed [PW-1:0]         p_q, prod_d;
  logic signed [W_WIDTH-1:0]    bias_q;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic signed [SW-1:0]         base, sum, max_ext, min_ext;

  assign prod_d  = PW'($signed({1'b0, act_i})) * PW'(w_i);
  assign max_ext = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  assign min_ext = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    base  = acc_first_i ? {{(SW-W_WIDTH){bias_q[W_WIDTH-1]}}, bias_q}
                        : {{(SW-DATA_WIDTH){acc_q[DATA_WIDTH-1]}}, acc_q};
    sum   = base + {{(SW-PW){p_q[PW-1]}}, p_q};
    acc_d = sum[DATA_WIDTH-1:0];
    if (sum > max_ext)      acc_d = max_ext[DATA_WIDTH-1:0];
    else if (sum < min_ext) acc_d = min_ext[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      bias_q <= '0;
      acc_q  <= '0;
    end else begin
      if (beat_i)            p_q    <= prod_d;
      if (beat_i && first_i) bias_q <= bias_i;
      if (acc_en_i)          acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/output_layer_acc.sv
// output_layer_acc: fully connected output layer. One activation plus its
// N_OUT weights arrive per beat; N_IN beats make a frame. Three stages:
// product register, saturating accumulate, output register with a
// one-cycle valid pulse.
//   clk, rst    clock, synchronous active-high reset
//   in_valid    beat present
//   in_ready    low only while rst is high (no back-pressure)
//   in_act      unsigned activation
//   in_weights  class j weight at [j*W_WIDTH +: W_WIDTH]
//   bias        class j bias, same packing, taken on a frame's first beat
//   layer_out   class j score at [j*DATA_WIDTH +: DATA_WIDTH], registered
//   valid       one-cycle pulse when layer_out holds a new frame
module output_layer_acc
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = fc_pkg::DATA_WIDTH,
  parameter int IN_WIDTH   = fc_pkg::IN_WIDTH,
  parameter int W_WIDTH    = fc_pkg::W_WIDTH,
  parameter int N_IN       = fc_pkg::N_IN,
  parameter int N_OUT      = fc_pkg::N_OUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_WIDTH-1:0]           in_act,
  input  logic [N_OUT*W_WIDTH-1:0]      in_weights,
  input  logic [N_OUT*W_WIDTH-1:0]      bias,
  output logic [N_OUT*DATA_WIDTH-1:0]   layer_out,
  output logic                          valid
);

  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;

  fc_state_e                   state_q;
  logic [CW-1:0]               beat_cnt_q;
  logic                        s1_vld_q, s1_first_q;
  // last-beat marker per stage; [3] is the valid pulse itself
  logic [3:1]                  last_pipe_q;
  logic [N_OUT*DATA_WIDTH-1:0] layer_out_q;
  logic [N_OUT*DATA_WIDTH-1:0] acc_flat;
  logic                        fire, first_beat, last_beat;

  assign in_ready   = ~rst;
  assign fire       = in_valid & in_ready;
  assign first_beat = fire & (state_q == IDLE);
  assign last_beat  = fire & (state_q == ACC) & (beat_cnt_q == CW'(N_IN-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      last_pipe_q <= '0;
      layer_out_q <= '0;
    end else begin
      if (fire) begin
        case (state_q)
          IDLE: begin
            beat_cnt_q <= CW'(1);
            state_q    <= ACC;
          end
          ACC: begin
            if (beat_cnt_q == CW'(N_IN-1)) begin
              beat_cnt_q <= '0;
              state_q    <= IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      s1_vld_q       <= fire;
      s1_first_q     <= first_beat;
      last_pipe_q[1] <= last_beat;
      last_pipe_q[2] <= last_pipe_q[1];
      last_pipe_q[3] <= last_pipe_q[2];
      // acc_flat is the pre-edge value, so a back-to-back frame restarting
      // the accumulators on this same edge does not disturb the copy.
      if (last_pipe_q[2]) layer_out_q <= acc_flat;
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    mac_sat_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .IN_WIDTH  (IN_WIDTH),
      .W_WIDTH   (W_WIDTH)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .beat_i     (fire),
      .first_i    (first_beat),
      .act_i      (in_act),
      .w_i        (in_weights[j*W_WIDTH +: W_WIDTH]),
      .bias_i     (bias[j*W_WIDTH +: W_WIDTH]),
      .acc_en_i   (s1_vld_q),
      .acc_first_i(s1_first_q),
      .acc_o      (acc_flat[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign layer_out = layer_out_q;
  assign valid     = last_pipe_q[3];

endmodule

// File: tb/tb_output_layer_acc.sv
// tb_output_layer_acc: drives a wide (29-bit) and a narrow (12-bit)
// instance with identical beats; expected scores come from a plain
// arithmetic model of bias + sum(act*w) with clamping after every beat.
module tb_output_layer_acc;

  localparam int NI = 32, NO = 10, DW0 = 29, DW1 = 12;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [7:0]        in_act = '0;
  logic [NO*8-1:0]   in_weights = '0, bias = '0;
  logic              ready0, ready1, valid0, valid1;
  logic [NO*DW0-1:0] lo0, prev0;
  logic [NO*DW1-1:0] lo1, prev1;

  output_layer_acc #(.DATA_WIDTH(DW0), .N_IN(NI)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready0), .in_act(in_act),
    .in_weights(in_weights), .bias(bias), .layer_out(lo0), .valid(valid0));
  output_layer_acc #(.DATA_WIDTH(DW1), .N_IN(NI)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready1), .in_act(in_act),
    .in_weights(in_weights), .bias(bias), .layer_out(lo1), .valid(valid1));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int act_a[NI];
  int w_a[NI][NO];
  int b_a[NO];
  longint e0[NO], e1[NO], ea0[NO], ea1[NO];
  logic [NO*DW0-1:0] cap0[$];
  logic [NO*DW1-1:0] cap1[$];
  int vcnt0 = 0, vcnt1 = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // capture every output frame; layer_out must never move without valid
  always @(negedge clk) begin
    if (valid0) begin cap0.push_back(lo0); vcnt0++; end
    if (valid1) begin cap1.push_back(lo1); vcnt1++; end
    if (!rst && !valid0) begin
      checks++;
      assert (lo0 === prev0) else begin
        errors++; $error("FAIL stable0: got %h expected %h", lo0, prev0);
      end
    end
    if (!rst && !valid1) begin
      checks++;
      assert (lo1 === prev1) else begin
        errors++; $error("FAIL stable1: got %h expected %h", lo1, prev1);
      end
    end
    prev0 = lo0;
    prev1 = lo1;
  end

  function automatic longint clampw(input longint v, input int dw);
    longint mx, mn;
    mx = (longint'(1) <<< (dw-1)) - 1;
    mn = -mx - 1;
    return (v > mx) ? mx : (v < mn) ? mn : v;
  endfunction

  task automatic model();
    for (int j = 0; j < NO; j++) begin
      e0[j] = b_a[j];
      e1[j] = b_a[j];
      for (int i = 0; i < NI; i++) begin
        e0[j] = clampw(e0[j] + longint'(act_a[i]) * w_a[i][j], DW0);
        e1[j] = clampw(e1[j] + longint'(act_a[i]) * w_a[i][j], DW1);
      end
    end
  endtask

  task automatic put_beat(input int i);
    @(negedge clk);
    in_valid = 1'b1;
    in_act   = act_a[i][7:0];
    for (int j = 0; j < NO; j++) begin
      in_weights[j*8 +: 8] = w_a[i][j][7:0];
      bias[j*8 +: 8]       = b_a[j][7:0];
    end
  endtask

  task automatic drive_frame(input int gap_pct, input bit tail_idle);
    for (int i = 0; i < NI; i++) begin
      while (i > 0 && $urandom_range(99) < gap_pct) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      put_beat(i);
    end
    if (tail_idle) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_vcnt(input int target, input string tag);
    int n = 0;
    while (vcnt0 < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, longint'(vcnt0 >= target), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_cap(input int idx0, input string tag);
    logic signed [DW0-1:0] t0;
    logic signed [DW1-1:0] t1;
    for (int j = 0; j < NO; j++) begin
      t0 = (idx0 < cap0.size()) ? cap0[idx0][j*DW0 +: DW0] : 'x;
      t1 = (idx0 < cap1.size()) ? cap1[idx0][j*DW1 +: DW1] : 'x;
      chk({tag, "_w"}, longint'(t0), e0[j]);
      chk({tag, "_n"}, longint'(t1), e1[j]);
    end
  endtask

  initial begin
    int base, best;
    logic signed [DW0-1:0] s0;
    logic signed [DW1-1:0] s1;

    // reset held 3 cycles with in_valid high
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", longint'(ready0), 0);
      chk("rst_valid", longint'(valid0), 0);
      chk("rst_lo", longint'(lo0 == '0 && lo1 == '0), 1);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", longint'(ready0 & ready1), 1);

    // single frame: act=1, w[j]=j, bias[j]=j -> 33*j, exact pulse timing
    for (int i = 0; i < NI; i++) begin
      act_a[i] = 1;
      for (int j = 0; j < NO; j++) w_a[i][j] = j;
    end
    for (int j = 0; j < NO; j++) b_a[j] = j;
    model();
    drive_frame(0, 1);                       // now just after edge k
    chk("vld_k", longint'(valid0), 0);
    @(negedge clk); chk("vld_k1", longint'(valid0), 0);
    @(negedge clk); chk("vld_k2", longint'(valid0 & valid1), 1);
    s0 = lo0[9*DW0 +: DW0];
    chk("single_c9", longint'(s0), 297);
    @(negedge clk); chk("vld_k3", longint'(valid0 | valid1), 0);
    chk("single_cnt", vcnt0, 1);
    check_cap(0, "single");

    // positive and negative saturation
    for (int i = 0; i < NI; i++) begin
      act_a[i] = 255;
      for (int j = 0; j < NO; j++) w_a[i][j] = 127;
    end
    for (int j = 0; j < NO; j++) b_a[j] = 0;
    model();
    drive_frame(0, 1);
    wait_vcnt(2, "pos_wait");
    check_cap(1, "pos_sat");
    s1 = cap1[1][4*DW1 +: DW1];
    chk("pos_2047", longint'(s1), 2047);

    for (int i = 0; i < NI; i++)
      for (int j = 0; j < NO; j++) w_a[i][j] = -128;
    model();
    drive_frame(0, 1);
    wait_vcnt(3, "neg_wait");
    check_cap(2, "neg_sat");
    s1 = cap1[2][0 +: DW1];
    chk("neg_2048", longint'(s1), -2048);

    // bubbles in frame A, frame B back-to-back with no gap
    idle(3);
    base = vcnt0;
    for (int i = 0; i < NI; i++) begin
      act_a[i] = int'($urandom_range(255));
      for (int j = 0; j < NO; j++) w_a[i][j] = int'($urandom_range(255)) - 128;
    end
    for (int j = 0; j < NO; j++) b_a[j] = int'($urandom_range(255)) - 128;
    model();
    ea0 = e0; ea1 = e1;
    drive_frame(40, 0);
    for (int i = 0; i < NI; i++) begin
      act_a[i] = int'($urandom_range(255));
      for (int j = 0; j < NO; j++) w_a[i][j] = int'($urandom_range(255)) - 128;
    end
    for (int j = 0; j < NO; j++) b_a[j] = int'($urandom_range(255)) - 128;
    model();
    drive_frame(0, 1);
    wait_vcnt(base + 2, "b2b_wait");
    idle(40);
    chk("b2b_pulses", vcnt0 - base, 2);
    chk("b2b_pulses_n", vcnt1 - base, 2);
    check_cap(base + 1, "b2b_B");
    e0 = ea0; e1 = ea1;
    check_cap(base, "b2b_A");

    // reset after beat 10, then a clean frame act=2, w=1, bias=0 -> 64
    base = vcnt0;
    for (int i = 0; i < 10; i++) put_beat(i);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      act_a[i] = 2;
      for (int j = 0; j < NO; j++) w_a[i][j] = 1;
    end
    for (int j = 0; j < NO; j++) b_a[j] = 0;
    model();
    drive_frame(0, 1);
    wait_vcnt(base + 1, "mid_rst_wait");
    idle(40);
    chk("mid_rst_pulses", vcnt0 - base, 1);
    check_cap(cap0.size() - 1, "mid_rst");
    s0 = cap0[cap0.size()-1][5*DW0 +: DW0];
    chk("mid_rst_64", longint'(s0), 64);

    // class 7 dominant, class 3 negative: argmax over the scores is 7
    base = vcnt0;
    for (int i = 0; i < NI; i++) begin
      act_a[i] = int'($urandom_range(255, 1));
      for (int j = 0; j < NO; j++) w_a[i][j] = int'($urandom_range(80)) - 40;
      w_a[i][7] = 100;
      w_a[i][3] = -50;
    end
    for (int j = 0; j < NO; j++) b_a[j] = 0;
    model();
    drive_frame(30, 1);
    wait_vcnt(base + 1, "cmp_wait");
    check_cap(base, "cmp");
    best = 0;
    for (int j = 1; j < NO; j++) begin
      logic signed [DW0-1:0] a, b;
      a = cap0[base][j*DW0 +: DW0];
      b = cap0[base][best*DW0 +: DW0];
      if (a > b) best = j;
    end
    chk("predict", best, 7);
    s0 = cap0[base][3*DW0 +: DW0];
    chk("class3_neg", longint'(s0 < 0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
